biquad8_pole_coeff_loader: RTL

Upstream coefficient sequencer for the biquad8 pole IIR. It holds a software-writable shadow bank of the four pole-matrix coefficients (A, B, C, D) and, on commit, serially shifts them into the IIR's 4-DSP B-cascade chain via `coeff_dat_o`/`coeff_wr_o`. It then issues a single `coeff_update_o` pulse so all four DSPs switch coefficients on the same clock. It sits between the register interface and the IIR's `coeff_dat_i`/`coeff_wr_i`/`coeff_update_i` ports, in the IIR clock domain.

---
 rtl/biquad8_pkg.sv | 34 +++
 rtl/biquad8_pole_coeff_loader_if.sv | 29 ++
 rtl/biquad8_pole_coeff_loader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/biquad8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : biquad8_pkg
// Description : Shared constants and types for the biquad8 pole coefficient path.
// Revision    : 1.0 - initial release
// ============================================================================
package biquad8_pkg;

    localparam int C_COEFF_W = 18;

    typedef logic [C_COEFF_W-1:0] coeff_t;

    localparam logic [1:0] C_ADDR_A = 2'd0;
    localparam logic [1:0] C_ADDR_B = 2'd1;
    localparam logic [1:0] C_ADDR_C = 2'd2;
    localparam logic [1:0] C_ADDR_D = 2'd3;

    // First entry is shifted first and therefore lands in DSP3 of the cascade.
    localparam logic [7:0] C_SHIFT_ORDER = {C_ADDR_C, C_ADDR_D, C_ADDR_B, C_ADDR_A};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    function automatic logic [1:0] shift_addr(input logic [1:0] idx);
        logic [1:0] rev;
        rev = 2'd3 - idx;
        return C_SHIFT_ORDER[{rev, 1'b0} +: 2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/biquad8_pole_coeff_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : biquad8_pole_coeff_loader_if
// Description : Register-side write/commit port and IIR-side coefficient port.
// Revision    : 1.0 - initial release
// ============================================================================
interface biquad8_pole_coeff_loader_if;

    logic                             wr_i;
    logic [1:0]                       addr_i;
    logic [biquad8_pkg::C_COEFF_W-1:0] dat_i;
    logic                             commit_i;
    logic                             busy_o;
    logic [biquad8_pkg::C_COEFF_W-1:0] coeff_dat_o;
    logic                             coeff_wr_o;
    logic                             coeff_update_o;

    modport master (
        output wr_i, addr_i, dat_i, commit_i,
        input  busy_o, coeff_dat_o, coeff_wr_o, coeff_update_o
    );

    modport slave (
        input  wr_i, addr_i, dat_i, commit_i,
        output busy_o, coeff_dat_o, coeff_wr_o, coeff_update_o
    );

endinterface
`default_nettype wire

// File: rtl/biquad8_pole_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module      : biquad8_pole_coeff_loader
// Description : Shadow/working coefficient banks and serial loader for the
//               biquad8 pole IIR B-cascade. Option: BIQUAD_COEFF_AUTOLOAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module biquad8_pole_coeff_loader
    import biquad8_pkg::*;
#(
    parameter coeff_t INIT_A = '0,
    parameter coeff_t INIT_B = '0,
    parameter coeff_t INIT_C = '0,
    parameter coeff_t INIT_D = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    biquad8_pole_coeff_loader_if.slave  bus
);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       pending_q, pending_d;
    coeff_t     shadow_q  [4];
    coeff_t     shadow_d  [4];
    coeff_t     working_q [4];
    coeff_t     working_d [4];
    logic       busy_q, busy_d;
    logic       wr_q, wr_d;
    logic       upd_q, upd_d;
    coeff_t     dat_q, dat_d;
    logic       auto_req;

`ifdef BIQUAD_COEFF_AUTOLOAD_EN
    logic boot_done_q, boot_done_d;

    assign boot_done_d = 1'b1;
    assign auto_req    = ~boot_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_done_q <= 1'b0;
        end else begin
            boot_done_q <= boot_done_d;
        end
    end
`else
    assign auto_req = 1'b0;
`endif

    always_comb begin
        shadow_d  = shadow_q;
        working_d = working_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        busy_d    = (state_q != ST_IDLE);
        wr_d      = 1'b0;
        upd_d     = 1'b0;
        dat_d     = '0;

        // shadow_d already carries this cycle's write, giving the snapshot bypass.
        if (bus.wr_i) begin
            shadow_d[bus.addr_i] = bus.dat_i;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.commit_i || auto_req) begin
                    working_d = shadow_d;
                    cnt_d     = 2'd0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                wr_d  = 1'b1;
                dat_d = working_q[shift_addr(cnt_q)];
                cnt_d = cnt_q + 2'd1;
                if (bus.commit_i) begin
                    pending_d = 1'b1;
                end
                if (cnt_q == 2'd3) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                upd_d = 1'b1;
                if (pending_q || bus.commit_i) begin
                    pending_d = 1'b0;
                    working_d = shadow_d;
                    cnt_d     = 2'd0;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 2'd0;
            pending_q <= 1'b0;
            shadow_q  <= '{INIT_A, INIT_B, INIT_C, INIT_D};
            working_q <= '{default: '0};
            busy_q    <= 1'b0;
            wr_q      <= 1'b0;
            upd_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            working_q <= working_d;
            busy_q    <= busy_d;
            wr_q      <= wr_d;
            upd_q     <= upd_d;
            dat_q     <= dat_d;
        end
    end

    assign bus.busy_o         = busy_q;
    assign bus.coeff_wr_o     = wr_q;
    assign bus.coeff_update_o = upd_q;
    assign bus.coeff_dat_o    = dat_q;

endmodule
`default_nettype wire
